mvu_rdc_reader: RTL and testbench

- Initiator/reader side of the MVU result-readout (rdc) port. The MVU exposes `mvu_rdc_en`/`mvu_rdc_addr` in and `mvu_rdc_grnt`/`mvu_rdc_word` out; this block drives that port.
- On a start command it reads `len` consecutive data-memory words from one selected MVU, beginning at `base_addr`.
- Returned words are buffered in a small FIFO and streamed out on a valid/ready interface with a last-word flag.
- Sits between the NMVU-wide rdc bus and a host/DMA result collector.

---
 rtl/mvu_rdc_reader.sv | 243 ++++++++++++++++++++++++
 tb/tb_mvu_rdc_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_rdc_reader.sv
// mvu_rdc_reader: reads len consecutive words from one MVU over the rdc port and
// streams them out as a valid/ready word stream with a last-word flag.
// Latency: request to out_valid is 2 cycles (1-cycle MVU read, then FIFO push).
// Backpressure: a request is issued only when the FIFO can absorb every read in flight.
// Ports: clk/rst; start/mvu_sel/base_addr/len command; busy/done status;
//        mvu_rdc_en/addr/grnt/word rdc bus; out_valid/out_ready/out_word/out_last stream.

// mvu_rdc_fifo: first-word-fall-through buffer for returned read words.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller must never push into a full FIFO without popping.
module mvu_rdc_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset: clearing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
endmodule

module mvu_rdc_reader #(
    parameter int NMVU       = 8,
    parameter int BDBANKA    = 15,
    parameter int BDBANKW    = 64,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(NMVU)-1:0]    mvu_sel,
    input  logic [BDBANKA-1:0]         base_addr,
    input  logic [LEN_W-1:0]           len,
    output logic                       busy,
    output logic                       done,
    output logic [NMVU-1:0]            mvu_rdc_en,
    output logic [NMVU*BDBANKA-1:0]    mvu_rdc_addr,
    input  logic [NMVU-1:0]            mvu_rdc_grnt,
    input  logic [NMVU*BDBANKW-1:0]    mvu_rdc_word,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BDBANKW-1:0]         out_word,
    output logic                       out_last
);
    localparam int SEL_W = $clog2(NMVU);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [BDBANKA-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   req_cnt_q, req_cnt_d;
    logic [LEN_W-1:0]   ret_cnt_q, ret_cnt_d;
    logic [LEN_W-1:0]   pop_cnt_q, pop_cnt_d;
    // A granted read returns exactly one cycle later, so one flag tracks it.
    logic               rd_pend_q, rd_pend_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_cnt;
    logic [BDBANKW-1:0] fifo_head;
    logic [BDBANKW-1:0] word_sel;
    logic [CW:0]        occupancy;
    logic               credit_ok;
    logic               req_vld;
    logic               req_hs;
    logic               last_pop;
    logic               pop_is_last;

    // Slots already spoken for: words buffered plus the read still in flight.
    assign occupancy   = {1'b0, fifo_cnt} + (CW+1)'(rd_pend_q);
    assign credit_ok   = (occupancy < (CW+1)'(FIFO_DEPTH));
    assign req_vld     = (state_q == S_REQ) && credit_ok;
    assign req_hs      = req_vld && mvu_rdc_grnt[sel_q];
    assign word_sel    = mvu_rdc_word[int'(sel_q)*BDBANKW +: BDBANKW];

    assign fifo_push   = rd_pend_q;
    assign fifo_pop    = out_valid && out_ready;
    assign pop_is_last = (pop_cnt_q == (len_q - LEN_W'(1)));
    assign last_pop    = fifo_pop && pop_is_last;

    mvu_rdc_fifo #(
        .WIDTH (BDBANKW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (word_sel),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        len_d     = len_q;
        req_cnt_d = req_cnt_q;
        ret_cnt_d = ret_cnt_q + LEN_W'(fifo_push);
        pop_cnt_d = pop_cnt_q + LEN_W'(fifo_pop);
        rd_pend_d = req_hs;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d     = mvu_sel;
                    addr_d    = base_addr;
                    len_d     = len;
                    req_cnt_d = '0;
                    ret_cnt_d = '0;
                    pop_cnt_d = '0;
                    state_d   = (len == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (req_hs) begin
                    addr_d    = addr_q + BDBANKA'(1);
                    req_cnt_d = req_cnt_q + LEN_W'(1);
                    if ((req_cnt_q + LEN_W'(1)) == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the final word is consumed so done follows it by one cycle.
                if (last_pop ||
                    (fifo_empty && !rd_pend_q && (ret_cnt_q == len_q))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            req_cnt_q <= '0;
            ret_cnt_q <= '0;
            pop_cnt_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            req_cnt_q <= req_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            pop_cnt_q <= pop_cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Only the selected MVU sees a request; every other bit and slice stays 0.
    always_comb begin
        mvu_rdc_en   = '0;
        mvu_rdc_addr = '0;
        if (req_vld) begin
            mvu_rdc_en[sel_q]                                 = 1'b1;
            mvu_rdc_addr[int'(sel_q)*BDBANKA +: BDBANKA]      = addr_q;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = !fifo_empty;
    // Stale storage is masked so the stream reads 0 whenever nothing is valid.
    assign out_word  = out_valid ? fifo_head : '0;
    assign out_last  = out_valid && pop_is_last;
endmodule

// File: tb/tb_mvu_rdc_reader.sv
module tb_mvu_rdc_reader;
    localparam int NMVU = 8, BDBANKA = 15, BDBANKW = 64, LEN_W = 16, FIFO_DEPTH = 4;
    localparam logic [63:0] TAG = 64'hA500_0000_0000_0000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [2:0]              mvu_sel;
    logic [BDBANKA-1:0]      base_addr;
    logic [LEN_W-1:0]        len_i;
    logic                    busy, done;
    logic [NMVU-1:0]         mvu_rdc_en;
    logic [NMVU*BDBANKA-1:0] mvu_rdc_addr;
    logic [NMVU-1:0]         mvu_rdc_grnt;
    logic [NMVU*BDBANKW-1:0] mvu_rdc_word;
    logic                    out_valid, out_ready, out_last;
    logic [BDBANKW-1:0]      out_word;

    int checks = 0, errors = 0;
    int cyc = 0;
    int cur_sel = 0;
    int start_cyc = 0;

    logic [BDBANKA-1:0] gnt_addr [$];
    int                 gnt_cyc  [$];
    logic [63:0]        pop_word [$];
    logic               pop_last [$];
    int                 pop_cyc  [$];
    int en_cycles = 0, done_cnt = 0, done_cyc = 0;
    int gnt_total = 0, pop_total = 0;
    logic               prev_stall = 1'b0;
    logic [BDBANKA-1:0] prev_addr = '0;
    logic [63:0]        mvu_word_r [NMVU];

    mvu_rdc_reader #(
        .NMVU(NMVU), .BDBANKA(BDBANKA), .BDBANKW(BDBANKW), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mvu_sel(mvu_sel), .base_addr(base_addr),
        .len(len_i), .busy(busy), .done(done), .mvu_rdc_en(mvu_rdc_en),
        .mvu_rdc_addr(mvu_rdc_addr), .mvu_rdc_grnt(mvu_rdc_grnt), .mvu_rdc_word(mvu_rdc_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // MVU model: registered read data, one cycle after a handshake; junk after reset.
    always @(posedge clk) begin
        for (int i = 0; i < NMVU; i++) begin
            if (rst)
                mvu_word_r[i] <= 64'hDEAD_0000_0000_0000 | 64'(i);
            else if (mvu_rdc_en[i] && mvu_rdc_grnt[i])
                mvu_word_r[i] <= TAG | 64'(mvu_rdc_addr[i*BDBANKA +: BDBANKA]);
        end
    end
    always_comb begin
        mvu_rdc_word = '0;
        for (int i = 0; i < NMVU; i++) mvu_rdc_word[i*BDBANKW +: BDBANKW] = mvu_word_r[i];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Passive monitor sampling on the falling edge.
    always @(negedge clk) begin
        logic [NMVU-1:0]         sel_mask;
        logic [NMVU*BDBANKA-1:0] amask;
        logic [BDBANKA-1:0]      a_sel;
        if (rst) begin
            gnt_total  = 0;
            pop_total  = 0;
            prev_stall = 1'b0;
        end else begin
            sel_mask = NMVU'(1) << cur_sel;
            a_sel    = mvu_rdc_addr[cur_sel*BDBANKA +: BDBANKA];
            if (mvu_rdc_en[cur_sel] && mvu_rdc_grnt[cur_sel]) begin
                gnt_addr.push_back(a_sel);
                gnt_cyc.push_back(cyc);
                gnt_total++;
            end
            if (|mvu_rdc_en) en_cycles++;
            if (out_valid && out_ready) begin
                pop_word.push_back(out_word);
                pop_last.push_back(out_last);
                pop_cyc.push_back(cyc);
                pop_total++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            amask = mvu_rdc_en[cur_sel] ? ({(NMVU*BDBANKA){1'b0}} | {BDBANKA{1'b1}}) << (cur_sel*BDBANKA) : '0;
            check("en_other_bits", 128'(mvu_rdc_en & ~sel_mask), 128'(0));
            check("addr_other_slices", 128'(mvu_rdc_addr & ~amask), 128'(0));
            if (prev_stall) begin
                check("stall_en_held", 128'(mvu_rdc_en[cur_sel]), 128'(1));
                check("stall_addr_held", 128'(a_sel), 128'(prev_addr));
            end
            prev_stall = mvu_rdc_en[cur_sel] && !mvu_rdc_grnt[cur_sel];
            prev_addr  = a_sel;
            check("no_overflow", 128'((gnt_total - pop_total) <= FIFO_DEPTH), 128'(1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input int sel, input logic [BDBANKA-1:0] base, input logic [LEN_W-1:0] n);
        cur_sel   = sel;
        mvu_sel   = 3'(sel);
        base_addr = base;
        len_i     = n;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 128'(done_cnt - d0), 128'(1));
    endtask

    task automatic check_xfer(input string tag, input int g0, input int p0,
                              input logic [BDBANKA-1:0] base, input int n);
        logic [BDBANKA-1:0] ea;
        check({tag, "_grants"}, 128'(gnt_addr.size() - g0), 128'(n));
        check({tag, "_words"}, 128'(pop_word.size() - p0), 128'(n));
        for (int k = 0; k < n; k++) begin
            ea = base + BDBANKA'(k);
            if (g0 + k < gnt_addr.size())
                check({tag, "_addr"}, 128'(gnt_addr[g0 + k]), 128'(ea));
            if (p0 + k < pop_word.size()) begin
                check({tag, "_word"}, 128'(pop_word[p0 + k]), 128'(TAG | 64'(ea)));
                check({tag, "_last"}, 128'(pop_last[p0 + k]), 128'(k == n - 1));
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_word"}, 128'(out_word), 128'(0));
        check({tag, "_last"}, 128'(out_last), 128'(0));
        check({tag, "_en"}, 128'(mvu_rdc_en), 128'(0));
        check({tag, "_addr"}, 128'(mvu_rdc_addr), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int g0, p0, d0, e0, n;
        rst = 1'b1; start = 1'b0; mvu_sel = '0; base_addr = '0; len_i = '0;
        mvu_rdc_grnt = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic read: MVU 2, 4 words from 0x0010, free-flowing.
        mvu_rdc_grnt = '1; out_ready = 1'b1;
        g0 = gnt_addr.size(); p0 = pop_word.size(); d0 = done_cnt; e0 = en_cycles;
        start_cmd(2, 15'h0010, 16'd4);
        check("busy_after_start", 128'(busy), 128'(1));
        wait_done(d0, 40, "basic_done");
        check_xfer("basic", g0, p0, 15'h0010, 4);
        check("basic_en_cycles", 128'(en_cycles - e0), 128'(4));
        if (gnt_cyc.size() >= g0 + 4)
            check("basic_back_to_back", 128'(gnt_cyc[g0 + 3] - gnt_cyc[g0]), 128'(3));
        if (pop_cyc.size() > 0)
            check("basic_done_after_pop", 128'(done_cyc - pop_cyc[pop_cyc.size() - 1]), 128'(1));
        check("basic_idle_busy", 128'(busy), 128'(0));

        // Grant stall: MVU 5 grant low 3 cycles on 2nd request, other grants high.
        g0 = gnt_addr.size(); p0 = pop_word.size(); d0 = done_cnt; e0 = en_cycles;
        start_cmd(5, 15'h0100, 16'd3);
        tick();
        mvu_rdc_grnt = 8'hDF;
        repeat (3) tick();
        mvu_rdc_grnt = '1;
        wait_done(d0, 40, "stall_done");
        check_xfer("stall", g0, p0, 15'h0100, 3);
        if (gnt_cyc.size() >= g0 + 2)
            check("stall_gap", 128'(gnt_cyc[g0 + 1] - gnt_cyc[g0]), 128'(4));
        check("stall_en_cycles", 128'(en_cycles - e0), 128'(6));

        // Backpressure: 10 words with the consumer stalled for 20 cycles.
        out_ready = 1'b0;
        g0 = gnt_addr.size(); p0 = pop_word.size(); d0 = done_cnt;
        start_cmd(1, 15'h0200, 16'd10);
        repeat (20) tick();
        check("bp_grants", 128'(gnt_addr.size() - g0), 128'(4));
        check("bp_no_pop", 128'(pop_word.size() - p0), 128'(0));
        check("bp_en_off", 128'(mvu_rdc_en), 128'(0));
        check("bp_head_valid", 128'(out_valid), 128'(1));
        check("bp_head_word", 128'(out_word), 128'(TAG | 64'h200));
        out_ready = 1'b1;
        wait_done(d0, 100, "bp_done");
        check_xfer("bp", g0, p0, 15'h0200, 10);

        // Address wrap, then zero length.
        g0 = gnt_addr.size(); p0 = pop_word.size(); d0 = done_cnt;
        start_cmd(7, 15'h7FFE, 16'd3);
        wait_done(d0, 40, "wrap_done");
        check_xfer("wrap", g0, p0, 15'h7FFE, 3);
        p0 = pop_word.size(); d0 = done_cnt; e0 = en_cycles;
        start_cmd(7, 15'h0123, 16'd0);
        check("zero_done_now", 128'(done), 128'(1));
        tick();
        check("zero_done_pulse", 128'(done), 128'(0));
        check("zero_done_count", 128'(done_cnt - d0), 128'(1));
        check("zero_done_latency", 128'(done_cyc - start_cyc), 128'(1));
        check("zero_no_en", 128'(en_cycles - e0), 128'(0));
        check("zero_no_words", 128'(pop_word.size() - p0), 128'(0));

        // Start while busy is ignored.
        g0 = gnt_addr.size(); p0 = pop_word.size(); d0 = done_cnt; e0 = en_cycles;
        start_cmd(3, 15'h0040, 16'd3);
        tick();
        mvu_sel = 3'd0; base_addr = 15'h0999; len_i = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0, 40, "busy_start_done");
        repeat (5) tick();
        check_xfer("busy_start", g0, p0, 15'h0040, 3);
        check("busy_start_one_done", 128'(done_cnt - d0), 128'(1));
        check("busy_start_en_cycles", 128'(en_cycles - e0), 128'(3));

        // Reset at the 2nd word aborts the transfer.
        p0 = pop_word.size(); d0 = done_cnt;
        start_cmd(4, 15'h0050, 16'd6);
        n = 0;
        while (pop_word.size() - p0 < 1 && n < 20) begin
            tick();
            n++;
        end
        check("rst_first_word_seen", 128'(pop_word.size() - p0), 128'(1));
        rst = 1'b1;
        tick();
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        repeat (8) tick();
        check("rst_no_done", 128'(done_cnt - d0), 128'(0));
        check("rst_fifo_empty", 128'(out_valid), 128'(0));

        g0 = gnt_addr.size(); p0 = pop_word.size(); d0 = done_cnt;
        start_cmd(4, 15'h0060, 16'd2);
        wait_done(d0, 40, "post_rst_done");
        check_xfer("post_rst", g0, p0, 15'h0060, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
